// File: rtl/wb_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave_pkg
// Description : Shared definitions for the Wishbone RAM responder and the
//               cpu-side bus logic (state encodings, default window base).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ram_slave_pkg;

  localparam logic [31:0] c_default_base_addr = 32'hb000_0000;
  localparam int          c_wait_cnt_w        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_ram_slave_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp
// Description : Single-port synchronous RAM, registered read (read-first).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave
// Description : Wishbone pipelined-mode RAM responder, one outstanding request,
//               programmable wait states, bus error on bad address.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = wb_ram_slave_pkg::c_default_base_addr,
  parameter int          ADDR_WIDTH  = 14,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_exception
);

  import wb_ram_slave_pkg::*;

  localparam logic [c_wait_cnt_w-1:0] c_wait_load =
    (WAIT_STATES > 0) ? c_wait_cnt_w'(WAIT_STATES - 1) : '0;

  wb_state_e                r_state;
  wb_state_e                w_state_nxt;
  logic [c_wait_cnt_w-1:0]  r_wait_cnt;
  logic [c_wait_cnt_w-1:0]  w_wait_cnt_nxt;
  logic                     r_valid;
  logic                     r_we;
  logic [ADDR_WIDTH-1:0]    r_idx;
  logic [31:0]              r_wdata;

  logic [30:0]              w_word_off;
  logic                     w_addr_ok;
  logic [ADDR_WIDTH-1:0]    w_bus_idx;
  logic                     w_accept;
  logic                     w_ram_we;
  logic [ADDR_WIDTH-1:0]    w_ram_addr;
  logic [31:0]              w_ram_rdata;

  // Word-granular offset; bit 30 is the borrow, set when below the base.
  assign w_word_off = {1'b0, i_wb_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign w_addr_ok  = ~w_word_off[30]
                    && (w_word_off[29:ADDR_WIDTH] == '0)
                    && (i_wb_addr[1:0] == 2'b00);
  assign w_bus_idx  = w_word_off[ADDR_WIDTH-1:0];
  assign w_accept   = i_wb_cyc && i_wb_stb && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_valid <= w_addr_ok;
      r_we    <= i_wb_we;
      r_idx   <= w_bus_idx;
      r_wdata <= i_wb_data;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    o_wb_stall     = 1'b1;
    o_wb_ack       = 1'b0;
    o_exception    = 1'b0;
    w_ram_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_wb_stall = 1'b0;
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = c_wait_load;
          end else begin
            w_state_nxt    = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt    = ST_ACK;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        // A master that drops cyc during the ack cycle abandons the request.
        if (i_wb_cyc) begin
          o_wb_ack    = 1'b1;
          o_exception = ~r_valid;
          w_ram_we    = r_valid & r_we;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // In IDLE the RAM is addressed straight from the bus so a zero-wait read
  // has its data registered by the time the ack cycle arrives.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_bus_idx : r_idx;

  assign o_wb_data  = (o_wb_ack && r_valid && !r_we) ? w_ram_rdata : 32'd0;

  ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_slave
// Description : Scoreboard bench for wb_ram_slave (WAIT_STATES 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_slave;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        cyc1, cyc3;
  logic [31:0] rdata1, rdata3;
  logic        ack1, ack3, stall1, stall3, exc1, exc3;
  logic [31:0] data_m;
  logic        ack_m, stall_m, exc_m;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_ack   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign cyc1    = cyc & ~sel;
  assign cyc3    = cyc & sel;
  assign ack_m   = sel ? ack3   : ack1;
  assign stall_m = sel ? stall3 : stall1;
  assign exc_m   = sel ? exc3   : exc1;
  assign data_m  = sel ? rdata3 : rdata1;

  wb_ram_slave #(.BASE_ADDR(32'hb000_0000), .ADDR_WIDTH(14), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_data(rdata1), .o_wb_ack(ack1),
    .o_wb_stall(stall1), .o_exception(exc1)
  );

  wb_ram_slave #(.BASE_ADDR(32'hb000_0000), .ADDR_WIDTH(14), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc3), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_data(rdata3), .o_wb_ack(ack3),
    .o_wb_stall(stall3), .o_exception(exc3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, stimulus moves 1 unit later.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("idle_dut_ack", {31'b0, sel ? ack1 : ack3}, 32'd0);
      if (ack_m) begin
        n_ack++;
        check("ack_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_data", data_m, e.data);
          check("ack_exc", {31'b0, exc_m}, {31'b0, e.exc});
          check("ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
        end
      end else begin
        check("idle_data", data_m, 32'd0);
        check("idle_exc", {31'b0, exc_m}, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_x, input bit push);
    int ws;
    int k;
    ws = sel ? 3 : 1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    k = 0;
    while (stall_m && k < 40) begin
      step();
      k++;
    end
    check("accept_stall", {31'b0, stall_m}, 32'd0);
    if (push) sb.push_back('{exp_d, exp_x, cyc_cnt + 1 + ws});
    step();
  endtask

  task automatic complete();
    int k;
    k   = 0;
    stb = 1'b0;
    while (sb.size() != 0 && k < 40) begin
      step();
      k++;
    end
    check("ack_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    step();
    cyc = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_x);
    issue(w, a, d, exp_d, exp_x, 1'b1);
    complete();
  endtask

  initial begin
    int n0;
    step(); step();
    check("rst_ack", {31'b0, ack1}, 32'd0);
    check("rst_stall", {31'b0, stall1}, 32'd0);
    check("rst_data", rdata1, 32'd0);
    check("rst_exc", {31'b0, exc1}, 32'd0);
    check("rst_stall3", {31'b0, stall3}, 32'd0);
    reset = 1'b1;
    step();

    // WAIT_STATES = 1 instance
    txn(1'b1, 32'hb000_0010, 32'hdead_beef, 32'd0, 1'b0);
    txn(1'b0, 32'hb000_0010, 32'd0, 32'hdead_beef, 1'b0);
    txn(1'b1, 32'hb000_fffc, 32'hcafe_f00d, 32'd0, 1'b0);
    txn(1'b0, 32'hb001_0000, 32'd0, 32'd0, 1'b1);
    txn(1'b0, 32'haffff_ffc, 32'd0, 32'd0, 1'b1);
    txn(1'b0, 32'hb000_fffc, 32'd0, 32'hcafe_f00d, 1'b0);
    txn(1'b1, 32'hb000_0000, 32'h1111_1111, 32'd0, 1'b0);
    txn(1'b1, 32'hb000_0002, 32'h2222_2222, 32'd0, 1'b1);
    txn(1'b0, 32'hb000_0000, 32'd0, 32'h1111_1111, 1'b0);

    // stb without cyc is ignored
    cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 32'hb000_0000; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nocyc_stall", {31'b0, stall_m}, 32'd0);
    end
    stb = 1'b0;
    txn(1'b0, 32'hb000_0000, 32'd0, 32'h1111_1111, 1'b0);

    // back-to-back with stb held high
    n0 = n_ack;
    issue(1'b1, 32'hb000_0020, 32'ha5a5_a5a5, 32'd0, 1'b0, 1'b1);
    we = 1'b0; wdata = 32'd0;
    check("b2b_stall_wait", {31'b0, stall_m}, 32'd1);
    step();
    check("b2b_stall_ack", {31'b0, stall_m}, 32'd1);
    step();
    check("b2b_idle_stall", {31'b0, stall_m}, 32'd0);
    issue(1'b0, 32'hb000_0020, 32'd0, 32'ha5a5_a5a5, 1'b0, 1'b1);
    complete();
    step(); step();
    check("b2b_ack_count", 32'(n_ack - n0), 32'd2);

    // reset asserted in the middle of WAIT
    txn(1'b1, 32'hb000_0040, 32'h0bad_c0de, 32'd0, 1'b0);
    issue(1'b1, 32'hb000_0040, 32'h7777_7777, 32'd0, 1'b0, 1'b0);
    stb = 1'b0;
    check("wait_stall", {31'b0, stall_m}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_ack", {31'b0, ack_m}, 32'd0);
    check("arst_stall", {31'b0, stall_m}, 32'd0);
    check("arst_data", data_m, 32'd0);
    check("arst_exc", {31'b0, exc_m}, 32'd0);
    step(); step();
    cyc = 1'b0;
    reset = 1'b1;
    step();
    check("post_rst_stall", {31'b0, stall_m}, 32'd0);
    step(); step();
    txn(1'b0, 32'hb000_0040, 32'd0, 32'h0bad_c0de, 1'b0);

    // WAIT_STATES = 3 instance
    sel = 1'b1;
    step();
    txn(1'b1, 32'hb000_0080, 32'h5555_aaaa, 32'd0, 1'b0);
    txn(1'b0, 32'hb000_0080, 32'd0, 32'h5555_aaaa, 1'b0);
    issue(1'b1, 32'hb000_0080, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    stb = 1'b0;
    step();
    check("ws3_wait_stall", {31'b0, stall_m}, 32'd1);
    cyc = 1'b0;
    step();
    check("abort_stall", {31'b0, stall_m}, 32'd0);
    step(); step(); step();
    txn(1'b0, 32'hb000_0080, 32'd0, 32'h5555_aaaa, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
